// File: rtl/esp32_prog_pkg.sv
// Shared definitions for the ESP32 programming bridge: FSM state encodings,
// DTR/RTS pattern constants, the strap decode and the parameter sanity check.
`timescale 1ns/1ps

package esp32_prog_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_RST  = 2'd1,
        ST_BOOT = 2'd2,
        ST_HOLD = 2'd3
    } prog_state_t;

    // Synced {dtr, rts} patterns as seen on the FTDI lines.
    localparam logic [1:0] PAT_IDLE  = 2'b11;
    localparam logic [1:0] PAT_RESET = 2'b10;
    localparam logic [1:0] PAT_BOOT  = 2'b01;

    // {dtr, rts} -> {en, io0}
    function automatic logic [1:0] decode_pat(input logic [1:0] pat);
        logic [1:0] res;
        res = 2'b11;
        if (pat == PAT_RESET)
            res = 2'b01;
        else if (pat == PAT_BOOT)
            res = 2'b10;
        return res;
    endfunction

    function automatic bit btn_fits(input int btn_bits, input int spi_bits);
        return btn_bits <= spi_bits;
    endfunction

endpackage

// File: rtl/esp32_prog_bridge_sync_edge.sv
// Multi-stage synchroniser with single-cycle rise/fall pulses on the
// synchronised value. All stages reset to C_RESET_VAL (idle-high lines).
`timescale 1ns/1ps

module sync_edge #(
    parameter int   C_STAGES    = 2,
    parameter logic C_RESET_VAL = 1'b1
) (
    input  logic clk_25mhz,
    input  logic reset,
    input  logic d,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [C_STAGES-1:0] chain;
    logic                last;

    // Shift the asynchronous input through the chain; keep last output for edges.
    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            chain <= {C_STAGES{C_RESET_VAL}};
            last  <= C_RESET_VAL;
        end else begin
            chain <= {chain[C_STAGES-2:0], d};
            last  <= chain[C_STAGES-1];
        end
    end

    assign sync = chain[C_STAGES-1];
    assign rise = sync & ~last;
    assign fall = ~sync & last;

endmodule

// File: rtl/esp32_prog_bridge.sv
// ESP32 programming / passthru bridge for ULX3S.
// UART passthru, DTR/RTS -> EN/GPIO0 programming FSM with timed strap hold,
// and an SPI slave returning button state over the shared MISO/strap pin.
// Optional build macro ACTIVITY_LED_EN adds stretched UART activity LEDs.
//
// state | meaning
// RUN   | normal operation, ESP32 running
// RST   | EN held low by FTDI
// BOOT  | EN released with GPIO0 low; one-cycle step into HOLD
// HOLD  | strap driven on shared pin for 2^C_RELEASE_BITS cycles
`timescale 1ns/1ps

module esp32_prog_bridge
    import esp32_prog_pkg::*;
#(
    parameter int C_SYNC_STAGES  = 2,
    parameter int C_RELEASE_BITS = 17,
    parameter int C_SPI_BITS     = 8,
    parameter int C_BTN_BITS     = 7,
    parameter int C_ACT_BITS     = 20
) (
    input  logic                  clk_25mhz,
    input  logic                  reset,
    input  logic                  ftdi_txd,
    output logic                  ftdi_rxd,
    input  logic                  wifi_txd,
    output logic                  wifi_rxd,
    input  logic                  ftdi_ndtr,
    input  logic                  ftdi_nrts,
    input  logic [C_BTN_BITS-1:0] btn,
    output logic                  wifi_en,
    output logic                  wifi_gpio0,
    input  logic                  spi_sck,
    input  logic                  spi_csn,
    output logic                  shared_out,
    output logic                  shared_oe,
    output logic                  prog_active,
    output logic [1:0]            state,
    output logic [1:0]            led_act
);

    if (!btn_fits(C_BTN_BITS, C_SPI_BITS)) begin : g_bad_btn_bits
        $error("C_BTN_BITS must not exceed C_SPI_BITS");
    end
    if (C_SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("C_SYNC_STAGES must be at least 2");
    end

    logic dtr_s, rts_s, sck_s, csn_s;
    logic dtr_rise, dtr_fall, rts_rise, rts_fall;
    logic sck_rise, sck_fall, csn_rise, csn_fall;
    logic unused_edges;

    assign ftdi_rxd = wifi_txd;
    assign wifi_rxd = ftdi_txd;

    sync_edge #(.C_STAGES(C_SYNC_STAGES), .C_RESET_VAL(1'b1)) u_sync_dtr (
        .clk_25mhz(clk_25mhz), .reset(reset), .d(ftdi_ndtr),
        .sync(dtr_s), .rise(dtr_rise), .fall(dtr_fall));
    sync_edge #(.C_STAGES(C_SYNC_STAGES), .C_RESET_VAL(1'b1)) u_sync_rts (
        .clk_25mhz(clk_25mhz), .reset(reset), .d(ftdi_nrts),
        .sync(rts_s), .rise(rts_rise), .fall(rts_fall));
    sync_edge #(.C_STAGES(C_SYNC_STAGES), .C_RESET_VAL(1'b1)) u_sync_sck (
        .clk_25mhz(clk_25mhz), .reset(reset), .d(spi_sck),
        .sync(sck_s), .rise(sck_rise), .fall(sck_fall));
    sync_edge #(.C_STAGES(C_SYNC_STAGES), .C_RESET_VAL(1'b1)) u_sync_csn (
        .clk_25mhz(clk_25mhz), .reset(reset), .d(spi_csn),
        .sync(csn_s), .rise(csn_rise), .fall(csn_fall));

    assign unused_edges = ^{dtr_rise, dtr_fall, rts_rise, rts_fall,
                            sck_s, sck_fall, csn_rise, csn_fall};

    logic [1:0] pat, pat_prev;
    logic [1:0] dec;
    logic       dec_en, dec_io0;
    logic       new_boot;

    assign pat      = {dtr_s, rts_s};
    assign dec      = decode_pat(pat);
    assign dec_en   = dec[1];
    assign dec_io0  = dec[0];
    // A boot pattern that was not already present last cycle (re)starts the hold.
    assign new_boot = (pat == PAT_BOOT) && (pat_prev != PAT_BOOT);

    prog_state_t               state_q, state_d;
    logic [C_RELEASE_BITS-1:0] cnt_q, cnt_d;

    // State, hold counter, previous pattern and the EN/GPIO0 output registers.
    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            pat_prev   <= PAT_IDLE;
            wifi_en    <= 1'b1;
            wifi_gpio0 <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pat_prev   <= pat;
            wifi_en    <= dec_en;
            wifi_gpio0 <= dec_io0 & btn[0];
        end
    end

    // Programming FSM next-state and hold counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (!dec_en)
                    state_d = ST_RST;
                else if (pat == PAT_BOOT && pat_prev == PAT_IDLE) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            end
            ST_RST: begin
                if (dec_en && !dec_io0)
                    state_d = ST_BOOT;
                else if (dec_en && dec_io0)
                    state_d = ST_RUN;
            end
            ST_BOOT: begin
                state_d = ST_HOLD;
                cnt_d   = '0;
            end
            ST_HOLD: begin
                if (!dec_en)
                    state_d = ST_RST;
                else if (new_boot)
                    cnt_d = '0;
                else if (&cnt_q)
                    state_d = ST_RUN;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign state       = state_q;
    assign prog_active = (state_q == ST_HOLD);

    logic [C_SPI_BITS-1:0] sr;
    logic                  miso;

    // SPI slave: reload buttons while deselected, rotate on each synced SCK rise.
    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset)
            sr <= '0;
        else if (csn_s)
            sr <= C_SPI_BITS'(btn);
        else if (sck_rise)
            sr <= {sr[C_SPI_BITS-2:0], sr[C_SPI_BITS-1]};
    end

    assign miso = sr[C_SPI_BITS-1];

    // Shared pin: the strap beats SPI so a boot never sees stray MISO data.
    always_comb begin
        shared_oe  = 1'b0;
        shared_out = 1'b0;
        if (state_q == ST_HOLD) begin
            shared_oe  = 1'b1;
            shared_out = dec_io0;
        end else if (!csn_s) begin
            shared_oe  = 1'b1;
            shared_out = miso;
        end
    end

`ifdef ACTIVITY_LED_EN
    logic ftx_s, ftx_rise, ftx_fall;
    logic wtx_s, wtx_rise, wtx_fall;
    logic [C_ACT_BITS:0] act_ftdi, act_wifi;
    logic unused_txd_sync;

    sync_edge #(.C_STAGES(C_SYNC_STAGES), .C_RESET_VAL(1'b1)) u_sync_ftx (
        .clk_25mhz(clk_25mhz), .reset(reset), .d(ftdi_txd),
        .sync(ftx_s), .rise(ftx_rise), .fall(ftx_fall));
    sync_edge #(.C_STAGES(C_SYNC_STAGES), .C_RESET_VAL(1'b1)) u_sync_wtx (
        .clk_25mhz(clk_25mhz), .reset(reset), .d(wifi_txd),
        .sync(wtx_s), .rise(wtx_rise), .fall(wtx_fall));

    assign unused_txd_sync = ftx_s ^ wtx_s;

    // Stretch counters: any edge reloads 2^C_ACT_BITS, then count down to zero.
    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            act_ftdi <= '0;
            act_wifi <= '0;
        end else begin
            if (ftx_rise || ftx_fall)
                act_ftdi <= (C_ACT_BITS+1)'(1) << C_ACT_BITS;
            else if (act_ftdi != '0)
                act_ftdi <= act_ftdi - 1'b1;
            if (wtx_rise || wtx_fall)
                act_wifi <= (C_ACT_BITS+1)'(1) << C_ACT_BITS;
            else if (act_wifi != '0)
                act_wifi <= act_wifi - 1'b1;
        end
    end

    assign led_act = {act_ftdi != '0, act_wifi != '0};
`else
    localparam int unused_act_bits = C_ACT_BITS;
    assign led_act = 2'b00;
`endif

endmodule

// File: tb/tb_esp32_prog_bridge.sv
// Self-checking bench for esp32_prog_bridge (C_RELEASE_BITS = 4, C_SYNC_STAGES = 2).
`timescale 1ns/1ps

module tb_esp32_prog_bridge;

    localparam int SYNC = 2;
    localparam int REL  = 4;
    localparam int HOLD_LEN = 1 << REL;

    logic       clk_25mhz = 1'b0;
    logic       reset;
    logic       ftdi_txd, wifi_txd, ftdi_ndtr, ftdi_nrts, spi_sck, spi_csn;
    logic [6:0] btn;
    logic       ftdi_rxd, wifi_rxd, wifi_en, wifi_gpio0;
    logic       shared_out, shared_oe, prog_active;
    logic [1:0] state, led_act;

    int n_cmp = 0;
    int n_bad = 0;

    esp32_prog_bridge #(
        .C_SYNC_STAGES(SYNC), .C_RELEASE_BITS(REL), .C_SPI_BITS(8),
        .C_BTN_BITS(7), .C_ACT_BITS(3)
    ) dut (
        .clk_25mhz(clk_25mhz), .reset(reset),
        .ftdi_txd(ftdi_txd), .ftdi_rxd(ftdi_rxd),
        .wifi_txd(wifi_txd), .wifi_rxd(wifi_rxd),
        .ftdi_ndtr(ftdi_ndtr), .ftdi_nrts(ftdi_nrts), .btn(btn),
        .wifi_en(wifi_en), .wifi_gpio0(wifi_gpio0),
        .spi_sck(spi_sck), .spi_csn(spi_csn),
        .shared_out(shared_out), .shared_oe(shared_oe),
        .prog_active(prog_active), .state(state), .led_act(led_act)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference MISO: button word zero-extended to 8 bits, rotated left k times, MSB.
    function automatic logic ref_miso(input logic [6:0] b, input int k);
        logic [7:0] w;
        int idx;
        w   = {1'b0, b};
        idx = 7 - (k % 8);
        return w[idx];
    endfunction

    task automatic set_pat(input logic d, input logic r);
        ftdi_ndtr = d;
        ftdi_nrts = r;
    endtask

    typedef struct {
        logic       ndtr, nrts, b0, ftx, wtx;
        int         wcyc;
        logic       exp_en, exp_g0;
        logic [1:0] exp_st;
    } vec_t;

    vec_t vecs[12];

    task automatic spi_run(input logic [6:0] b, input int pulses, input int low_ns);
        btn     = b;
        spi_csn = 1'b1;
        spi_sck = 1'b0;
        repeat (4) @(negedge clk_25mhz);
        spi_csn = 1'b0;
        #1000;
        for (int k = 0; k < pulses; k++) begin
            chk($sformatf("spi_oe b=%0h k=%0d", b, k), 32'(shared_oe), 32'd1);
            chk($sformatf("spi_miso b=%0h k=%0d", b, k), 32'(shared_out), 32'(ref_miso(b, k)));
            spi_sck = 1'b1;
            #500;
            spi_sck = 1'b0;
            #(low_ns);
        end
        chk($sformatf("spi_miso_end b=%0h k=%0d", b, pulses), 32'(shared_out), 32'(ref_miso(b, pulses)));
        spi_csn = 1'b1;
        #400;
        chk("spi_release_oe", 32'(shared_oe), 32'd0);
    endtask

    initial begin
        int  hold_n, bad_hold, led_n, led0_n;
        bit  seen_boot, boot_before_hold, done;
        logic ft, wt;

        vecs[0]  = '{1,1,1,0,1, 6, 1,1,2'd0};
        vecs[1]  = '{1,1,0,1,0, 6, 1,0,2'd0};
        vecs[2]  = '{1,0,1,0,0, 6, 0,1,2'd1};
        vecs[3]  = '{0,0,1,1,1, 6, 1,1,2'd0};
        vecs[4]  = '{0,1,1,0,1, 6, 1,0,2'd0};
        vecs[5]  = '{1,1,1,1,0, 6, 1,1,2'd0};
        vecs[6]  = '{0,1,1,1,1, 8, 1,0,2'd3};
        vecs[7]  = '{0,1,1,0,0,24, 1,0,2'd0};
        vecs[8]  = '{1,0,1,1,1, 6, 0,1,2'd1};
        vecs[9]  = '{0,1,1,0,1, 6, 1,0,2'd3};
        vecs[10] = '{0,0,1,1,0, 4, 1,1,2'd3};
        vecs[11] = '{1,1,1,1,1,24, 1,1,2'd0};

        reset = 1'b1;
        ftdi_txd = 1'b1; wifi_txd = 1'b1;
        set_pat(1'b1, 1'b1);
        spi_sck = 1'b0; spi_csn = 1'b1;
        btn = 7'h7F;

        // Reset state
        repeat (3) @(negedge clk_25mhz);
        chk("rst_en", 32'(wifi_en), 32'd1);
        chk("rst_oe", 32'(shared_oe), 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk_25mhz);
        chk("post_rst_state", 32'(state), 32'd0);
        chk("post_rst_en", 32'(wifi_en), 32'd1);
        chk("post_rst_gpio0", 32'(wifi_gpio0), 32'd1);
        chk("post_rst_oe", 32'(shared_oe), 32'd0);
        chk("post_rst_out", 32'(shared_out), 32'd0);
        chk("post_rst_prog", 32'(prog_active), 32'd0);
        chk("post_rst_led", 32'(led_act), 32'd0);

        // Table-driven decode / state vectors
        for (int i = 0; i < 12; i++) begin
            set_pat(vecs[i].ndtr, vecs[i].nrts);
            btn[0]   = vecs[i].b0;
            ftdi_txd = vecs[i].ftx;
            wifi_txd = vecs[i].wtx;
            repeat (vecs[i].wcyc) @(negedge clk_25mhz);
            chk($sformatf("vec%0d_en", i), 32'(wifi_en), 32'(vecs[i].exp_en));
            chk($sformatf("vec%0d_gpio0", i), 32'(wifi_gpio0), 32'(vecs[i].exp_g0));
            chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].exp_st));
            chk($sformatf("vec%0d_oe", i), 32'(shared_oe), 32'(vecs[i].exp_st == 2'd3));
            chk($sformatf("vec%0d_prog", i), 32'(prog_active), 32'(vecs[i].exp_st == 2'd3));
            chk($sformatf("vec%0d_ftdi_rxd", i), 32'(ftdi_rxd), 32'(vecs[i].wtx));
            chk($sformatf("vec%0d_wifi_rxd", i), 32'(wifi_rxd), 32'(vecs[i].ftx));
`ifndef ACTIVITY_LED_EN
            chk($sformatf("vec%0d_led", i), 32'(led_act), 32'd0);
`endif
        end
        ftdi_txd = 1'b1; wifi_txd = 1'b1; btn = 7'h7F;

        // Programming sequence via RST/BOOT with exact hold length
        set_pat(1'b1, 1'b0);
        repeat (50) @(negedge clk_25mhz);
        chk("prog_rst_state", 32'(state), 32'd1);
        chk("prog_rst_en", 32'(wifi_en), 32'd0);
        set_pat(1'b0, 1'b1);
        seen_boot = 0; boot_before_hold = 0; hold_n = 0; bad_hold = 0; done = 0;
        for (int i = 0; i < 80 && !done; i++) begin
            @(negedge clk_25mhz);
            if (state == 2'd2) seen_boot = 1;
            if (state == 2'd3) begin
                if (hold_n == 0) boot_before_hold = seen_boot;
                hold_n++;
                if (wifi_en !== 1'b1 || wifi_gpio0 !== 1'b0 || shared_oe !== 1'b1 ||
                    shared_out !== 1'b0 || prog_active !== 1'b1)
                    bad_hold++;
            end else if (hold_n > 0) begin
                done = 1;
            end
        end
        chk("prog_done", 32'(done), 32'd1);
        chk("prog_boot_before_hold", 32'(boot_before_hold), 32'd1);
        chk("prog_hold_len", 32'(hold_n), 32'(HOLD_LEN));
        chk("prog_hold_outputs_bad", 32'(bad_hold), 32'd0);
        chk("prog_end_state", 32'(state), 32'd0);

        // Retrigger: 11 then 01 during HOLD cycle 10
        set_pat(1'b1, 1'b1);
        repeat (4) @(negedge clk_25mhz);
        set_pat(1'b0, 1'b1);
        hold_n = 0; done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk_25mhz);
            if (state == 2'd3) begin
                hold_n++;
                if (hold_n == 10) set_pat(1'b1, 1'b1);
                if (hold_n == 11) set_pat(1'b0, 1'b1);
            end else if (hold_n > 0) begin
                done = 1;
            end
        end
        chk("retrig_done", 32'(done), 32'd1);
        chk("retrig_hold_len", 32'(hold_n), 32'(11 + SYNC + HOLD_LEN));
        chk("retrig_end_state", 32'(state), 32'd0);

        // Reset asserted during HOLD cycle 5
        set_pat(1'b1, 1'b1);
        repeat (4) @(negedge clk_25mhz);
        set_pat(1'b0, 1'b1);
        hold_n = 0; done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk_25mhz);
            if (state == 2'd3) hold_n++;
            if (hold_n == 5) done = 1;
        end
        chk("midhold_reached", 32'(done), 32'd1);
        chk("midhold_oe_before", 32'(shared_oe), 32'd1);
        reset = 1'b1;
        #1;
        chk("midhold_rst_state", 32'(state), 32'd0);
        chk("midhold_rst_oe", 32'(shared_oe), 32'd0);
        chk("midhold_rst_en", 32'(wifi_en), 32'd1);
        chk("midhold_rst_gpio0", 32'(wifi_gpio0), 32'd1);
        chk("midhold_rst_prog", 32'(prog_active), 32'd0);
        ftdi_txd = 1'b0; wifi_txd = 1'b1;
        #2;
        chk("rst_uart_ftdi_rxd", 32'(ftdi_rxd), 32'd1);
        chk("rst_uart_wifi_rxd", 32'(wifi_rxd), 32'd0);
        ftdi_txd = 1'b1;
        set_pat(1'b1, 1'b1);
        repeat (3) @(negedge clk_25mhz);
        reset = 1'b0;
        repeat (6) @(negedge clk_25mhz);
        chk("after_midhold_state", 32'(state), 32'd0);

        // SPI: fixed pattern then randomized against the rotate model
        spi_run(7'b1010101, 8, 500);
        for (int r = 0; r < 6; r++)
            spi_run(7'($urandom), int'($urandom_range(1, 12)), int'($urandom_range(200, 600)));
        chk("spi_state_run", 32'(state), 32'd0);

        // Randomized UART passthru
        for (int r = 0; r < 8; r++) begin
            ft = 1'($urandom); wt = 1'($urandom);
            ftdi_txd = ft; wifi_txd = wt;
            #3;
            chk($sformatf("uart_ftdi_rxd r%0d", r), 32'(ftdi_rxd), 32'(wt));
            chk($sformatf("uart_wifi_rxd r%0d", r), 32'(wifi_rxd), 32'(ft));
        end

        // Activity LEDs
        ftdi_txd = 1'b1; wifi_txd = 1'b1;
        repeat (16) @(negedge clk_25mhz);
        ftdi_txd = 1'b0;
        led_n = 0; led0_n = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk_25mhz);
            if (led_act[1] === 1'b1) led_n++;
            if (led_act[0] === 1'b1) led0_n++;
        end
`ifdef ACTIVITY_LED_EN
        chk("led_ftdi_cycles", 32'(led_n), 32'd8);
`else
        chk("led_ftdi_cycles", 32'(led_n), 32'd0);
`endif
        chk("led_wifi_cycles", 32'(led0_n), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/esp32_prog_bridge.md
Name: esp32_prog_bridge

Overview:
- Parametrised next-generation ESP32 programming/passthru bridge for ULX3S.
- Passes the FTDI UART straight through to the ESP32 UART.
- Decodes FTDI DTR/RTS into ESP32 EN/GPIO0, with synchronisers, an explicit programming FSM and a timed strap hold.
- Contains a clock-domain-safe SPI slave that returns button state to the ESP32 over a shared MISO/strap pin.

Parameters:
- C_SYNC_STAGES, 2: synchroniser depth for all asynchronous inputs; minimum 2.
- C_RELEASE_BITS, 17: strap hold lasts 2^C_RELEASE_BITS clk_25mhz cycles.
- C_SPI_BITS, 8: SPI shift register width.
- C_BTN_BITS, 7: button count; must be <= C_SPI_BITS (elaboration error otherwise).
- C_ACT_BITS, 20: activity LED stretch is 2^C_ACT_BITS cycles (used only with the optional feature).

Ports:
- clk_25mhz, in, 1: sole clock.
- reset, in, 1: asynchronous, active-high.
- ftdi_txd, in, 1: FTDI UART TX.
- ftdi_rxd, out, 1: to FTDI; equals wifi_txd, combinational.
- wifi_txd, in, 1: ESP32 UART TX.
- wifi_rxd, out, 1: to ESP32; equals ftdi_txd, combinational.
- ftdi_ndtr, in, 1: FTDI DTR, asynchronous.
- ftdi_nrts, in, 1: FTDI RTS, asynchronous.
- btn, in, C_BTN_BITS: buttons, asynchronous; btn[0] forces GPIO0 low.
- wifi_en, out, 1: ESP32 EN, registered.
- wifi_gpio0, out, 1: ESP32 GPIO0, registered.
- spi_sck, in, 1: SPI clock from ESP32, asynchronous.
- spi_csn, in, 1: SPI chip select from ESP32, asynchronous.
- shared_out, out, 1: value for the shared MISO/strap pin.
- shared_oe, out, 1: output enable for the shared pin; the top level tristates it.
- prog_active, out, 1: high while in HOLD.
- state, out, 2: current FSM state.
- led_act, out, 2: {ftdi_txd activity, wifi_txd activity}.

Behaviour:
- UART path:
  - Pure wires, zero latency.
  - Unaffected by reset.
- Synchronisers:
  - ndtr, nrts, sck and csn each pass through a C_SYNC_STAGES flop chain.
  - All stages reset to 1.
- Decode of synced {dtr,rts} to {en,io0}:
  - 10 -> 01
  - 01 -> 10
  - else -> 11
- Output registers:
  - wifi_en <= en.
  - wifi_gpio0 <= io0 & btn[0].
  - One cycle after decode.
- FSM states (encoding given by `state`):
  - RUN = 0
  - RST = 1
  - BOOT = 2
  - HOLD = 3
- Reset values:
  - state = RUN, counter = 0.
  - wifi_en = 1, wifi_gpio0 = 1.
  - prog_active = 0.
  - shared_oe = 0, shared_out = 0.
  - led_act = 0.
- FSM transitions:
  - RUN -> RST when decoded en = 0.
  - RST -> BOOT when decoded io0 = 0 and en = 1.
  - RST -> RUN when decode returns to 11.
  - BOOT -> HOLD on the next cycle; counter cleared.
  - Direct RUN with synced pattern 01 while the previous synced pattern was 11 -> HOLD, counter cleared.
  - HOLD: counter increments every cycle.
  - HOLD -> RUN on the cycle the counter reaches 2^C_RELEASE_BITS - 1. HOLD therefore lasts exactly 2^C_RELEASE_BITS cycles.
  - A new 01 edge during HOLD clears the counter (retrigger) and stays in HOLD.
  - en = 0 during HOLD -> RST.
- SPI slave:
  - Shift register sr[C_SPI_BITS-1:0].
  - While synced csn = 1: sr <= zero-extended btn every cycle.
  - While csn = 0: each synced sck rising edge rotates sr left, i.e. sr <= {sr[C_SPI_BITS-2:0], sr[C_SPI_BITS-1]}.
  - MISO = sr[C_SPI_BITS-1].
  - Maximum SCK = clk_25mhz / (2·(C_SYNC_STAGES+1)); faster SCK is unsupported.
- Shared pin priority:
  - In HOLD: shared_oe = 1, shared_out = decoded io0 (strap).
  - Else if csn = 0: shared_oe = 1, shared_out = MISO.
  - Else: shared_oe = 0.
- Reset mid-HOLD:
  - Returns to RUN immediately.
  - Shared pin released asynchronously.
- Simultaneous csn falling edge and HOLD entry: strap wins; SPI data in that window is undefined.

Optional Feature:
- Macro: ACTIVITY_LED_EN.
- With the macro defined:
  - Each synced edge on ftdi_txd or wifi_txd reloads that channel's C_ACT_BITS down-counter.
  - led_act[i] = (counter != 0).
  - The txd inputs get their own synchronisers.
- Without the macro: led_act tied 0; no counters or synchronisers are generated.

Decomposition:
- Package esp32_prog_pkg:
  - state encodings (RUN, RST, BOOT, HOLD)
  - decode pattern constants
  - the C_BTN_BITS <= C_SPI_BITS check function
- Sub-module sync_edge: parametrised synchroniser plus rise/fall pulse outputs, instantiated for ndtr, nrts, sck, csn (and for the txd lines when ACTIVITY_LED_EN is defined).

Test Plan (bench uses C_RELEASE_BITS = 4, C_SYNC_STAGES = 2):
- Reset release, DTR/RTS = 11 -> wifi_en = 1, wifi_gpio0 = 1, state = 0, shared_oe = 0.
- Sequence {dtr,rts} = 10 for 50 cycles, then 01 -> state passes 1, 2, then 3.
  - While in 3: wifi_en = 1, wifi_gpio0 = 0, shared_oe = 1, shared_out = 0, for exactly 16 cycles.
  - Then state = 0.
- Retrigger: during HOLD cycle 10, apply 11 then 01 -> counter restarts; HOLD ends 16 cycles after the second 01.
- btn = 7'b1010101, csn low, 8 SCK pulses at 1 MHz -> MISO sequence 0,1,0,1,0,1,0,1 (MSB first), then wraps to the initial value.
- Assert reset during HOLD cycle 5 -> shared_oe = 0 and state = 0 immediately; wifi_en = 1 and wifi_gpio0 = 1.
- With ACTIVITY_LED_EN (C_ACT_BITS = 3): one toggle on ftdi_txd -> led_act[1] high for 8 cycles, led_act[0] stays 0. Without the macro: led_act stays 0.
